// File: rtl/fir_fifo_imem.sv
// fir_fifo_imem
// Sample FIFO and a 64-word synchronous single-port memory sharing one clock
// and one reset. The two blocks are completely independent.
//
// Ports:
//   clk         rising-edge clock for all logic
//   rstn        asynchronous active-low reset
//   valid_in    FIFO write request, din sampled at the edge
//   din         FIFO write data
//   rd_en       FIFO read request, head popped at the edge
//   fifo_out    registered FIFO read data (holds last popped value)
//   fifo_empty  FIFO holds no entries
//   fifo_full   FIFO holds DEPTH entries
//   CEN         memory chip enable, active-low
//   WEN         memory write enable, active-low
//   A           memory word address
//   D           memory write data
//   Q           registered memory read data
module fir_fifo_imem #(
  parameter int DEPTH = 16,
  parameter int DW    = 16
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          valid_in,
  input  logic [DW-1:0] din,
  input  logic          rd_en,
  output logic [DW-1:0] fifo_out,
  output logic          fifo_empty,
  output logic          fifo_full,
  input  logic          CEN,
  input  logic          WEN,
  input  logic [5:0]    A,
  input  logic [DW-1:0] D,
  output logic [DW-1:0] Q
);

  localparam int            AW         = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);

  logic [DW-1:0] r_fifoMem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic [DW-1:0] r_fifoOut;

  logic [DW-1:0] r_mem [64];
  logic [DW-1:0] r_q;

  logic w_wrAccept;
  logic w_rdAccept;

  // Flags come straight from the registered count; a write or read is only
  // accepted against the flag values seen before the edge, so a full FIFO
  // drops a simultaneous write and an empty FIFO never bypasses new data.
  assign fifo_empty = (r_count == '0);
  assign fifo_full  = (r_count == FULL_COUNT);
  assign w_wrAccept = valid_in && !fifo_full;
  assign w_rdAccept = rd_en && !fifo_empty;

  assign fifo_out = r_fifoOut;
  assign Q        = r_q;

  // FIFO storage and write pointer. Pointers are exactly log2(DEPTH) bits so
  // they wrap from DEPTH-1 to 0 on their own.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_fifoMem[i] <= '0;
      end
    end else if (w_wrAccept) begin
      r_fifoMem[r_wptr] <= din;
      r_wptr            <= r_wptr + 1'b1;
    end
  end

  // Read pointer and output register; fifo_out only changes on an accepted pop.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rptr    <= '0;
      r_fifoOut <= '0;
    end else if (w_rdAccept) begin
      r_fifoOut <= r_fifoMem[r_rptr];
      r_rptr    <= r_rptr + 1'b1;
    end
  end

  // Occupancy: a simultaneous accepted write and read leaves it unchanged.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_count <= '0;
    end else begin
      case ({w_wrAccept, w_rdAccept})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Single-port memory: a write leaves Q untouched, a read updates Q one
  // cycle later, and a disabled chip ignores WEN, A and D entirely.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_q <= '0;
      for (int i = 0; i < 64; i++) begin
        r_mem[i] <= '0;
      end
    end else if (!CEN) begin
      if (!WEN) begin
        r_mem[A] <= D;
      end else begin
        r_q <= r_mem[A];
      end
    end
  end

endmodule

// File: tb/tb_fir_fifo_imem.sv
// tb_fir_fifo_imem
// Directed bench for fir_fifo_imem. A queue model of the FIFO predicts which
// requests are accepted; popped values go onto an expected-output queue that
// is compared against fifo_out after the edge. A 64-word array models the
// memory and its Q register.
module tb_fir_fifo_imem;

  localparam int DEPTH = 16;
  localparam int DW    = 16;

  logic          clk;
  logic          rstn;
  logic          valid_in;
  logic [DW-1:0] din;
  logic          rd_en;
  logic [DW-1:0] fifo_out;
  logic          fifo_empty;
  logic          fifo_full;
  logic          CEN;
  logic          WEN;
  logic [5:0]    A;
  logic [DW-1:0] D;
  logic [DW-1:0] Q;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] modelQ [$];
  logic [DW-1:0] expOut [$];
  logic [DW-1:0] lastOut;
  logic [DW-1:0] memModel [64];
  logic [DW-1:0] qModel;

  fir_fifo_imem #(.DEPTH(DEPTH), .DW(DW)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .valid_in   (valid_in),
    .din        (din),
    .rd_en      (rd_en),
    .fifo_out   (fifo_out),
    .fifo_empty (fifo_empty),
    .fifo_full  (fifo_full),
    .CEN        (CEN),
    .WEN        (WEN),
    .A          (A),
    .D          (D),
    .Q          (Q)
  );

  // 100 MHz clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counts it, and on mismatch counts the failure and reports.
  task automatic checkOutput(input string tag, input logic [DW-1:0] observed,
                             input logic [DW-1:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // One FIFO cycle. Acceptance is decided from the model occupancy before the
  // edge; inputs are driven 1 time unit after a rising edge and outputs are
  // checked 1 time unit after the next one.
  task automatic applyStimulus(input logic wv, input logic [DW-1:0] wd,
                               input logic rv);
    logic          acceptW;
    logic          acceptR;
    logic [DW-1:0] expVal;
    acceptW = wv && (modelQ.size() < DEPTH);
    acceptR = rv && (modelQ.size() > 0);
    if (acceptR) begin
      expOut.push_back(modelQ.pop_front());
    end
    if (acceptW) begin
      modelQ.push_back(wd);
    end
    valid_in = wv;
    din      = wd;
    rd_en    = rv;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    rd_en    = 1'b0;
    if (acceptR) begin
      expVal  = expOut.pop_front();
      lastOut = expVal;
      checkOutput("fifo_out_pop", fifo_out, expVal);
    end else begin
      checkOutput("fifo_out_hold", fifo_out, lastOut);
    end
    checkOutput("fifo_empty", {15'd0, fifo_empty}, {15'd0, modelQ.size() == 0});
    checkOutput("fifo_full", {15'd0, fifo_full}, {15'd0, modelQ.size() == DEPTH});
  endtask

  // One memory cycle with Q checked one cycle after the address is applied.
  task automatic applyMemStimulus(input logic cen, input logic wen,
                                  input logic [5:0] addr, input logic [DW-1:0] data);
    if (!cen) begin
      if (!wen) memModel[addr] = data;
      else      qModel = memModel[addr];
    end
    CEN = cen;
    WEN = wen;
    A   = addr;
    D   = data;
    @(posedge clk);
    #1;
    CEN = 1'b1;
    WEN = 1'b1;
    checkOutput("mem_Q", Q, qModel);
  endtask

  initial begin
    rstn     = 1'b0;
    valid_in = 1'b0;
    din      = '0;
    rd_en    = 1'b0;
    CEN      = 1'b1;
    WEN      = 1'b1;
    A        = '0;
    D        = '0;
    lastOut  = '0;
    qModel   = '0;
    for (int i = 0; i < 64; i++) memModel[i] = '0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_fifo_out", fifo_out, 16'h0000);
    checkOutput("rst_empty", {15'd0, fifo_empty}, 16'h0001);
    checkOutput("rst_full", {15'd0, fifo_full}, 16'h0000);
    checkOutput("rst_Q", Q, 16'h0000);
    rstn = 1'b1;

    $display("[TB] read of empty FIFO after reset");
    applyStimulus(1'b0, 16'h0000, 1'b1);
    applyStimulus(1'b0, 16'h0000, 1'b1);

    $display("[TB] three writes then three reads");
    applyStimulus(1'b1, 16'd100, 1'b0);
    applyStimulus(1'b1, 16'hFF38, 1'b0);
    applyStimulus(1'b1, 16'd300, 1'b0);
    applyStimulus(1'b0, 16'h0000, 1'b1);
    applyStimulus(1'b0, 16'h0000, 1'b1);
    checkOutput("neg_sample", fifo_out, 16'hFF38);
    applyStimulus(1'b0, 16'h0000, 1'b1);
    checkOutput("empty_after_3", {15'd0, fifo_empty}, 16'h0001);

    $display("[TB] overfill with 17 writes, then drain");
    for (int v = 1; v <= 17; v++) applyStimulus(1'b1, 16'(v), 1'b0);
    checkOutput("full_after_17", {15'd0, fifo_full}, 16'h0001);
    for (int v = 1; v <= 16; v++) applyStimulus(1'b0, 16'h0000, 1'b1);
    checkOutput("last_drained", fifo_out, 16'd16);
    applyStimulus(1'b0, 16'h0000, 1'b1);

    $display("[TB] simultaneous read/write when full, then across wrap");
    for (int v = 1; v <= 16; v++) applyStimulus(1'b1, 16'(v), 1'b0);
    applyStimulus(1'b1, 16'd17, 1'b1);
    checkOutput("full_rw_pop", fifo_out, 16'd1);
    for (int k = 0; k < 7; k++) applyStimulus(1'b0, 16'h0000, 1'b1);
    for (int k = 0; k < 12; k++) applyStimulus(1'b1, 16'(16'h0A00 + k), 1'b1);
    while (modelQ.size() > 0) applyStimulus(1'b0, 16'h0000, 1'b1);
    applyStimulus(1'b1, 16'h5A5A, 1'b1);
    applyStimulus(1'b0, 16'h0000, 1'b1);

    $display("[TB] memory write/read sweep");
    for (int a = 0; a < 64; a++) applyMemStimulus(1'b0, 1'b0, 6'(a), 16'(a * 3));
    for (int a = 0; a < 64; a++) applyMemStimulus(1'b0, 1'b1, 6'(a), 16'h0000);
    checkOutput("mem_last", Q, 16'd189);
    applyMemStimulus(1'b1, 1'b1, 6'd5, 16'h0000);
    applyMemStimulus(1'b1, 1'b0, 6'd5, 16'hBEEF);
    applyMemStimulus(1'b0, 1'b1, 6'd5, 16'h0000);
    checkOutput("mem_cen_blocked", Q, 16'd15);

    $display("[TB] asynchronous reset mid-operation");
    for (int v = 0; v < 6; v++) applyStimulus(1'b1, 16'(16'h0100 + v), 1'b0);
    applyStimulus(1'b0, 16'h0000, 1'b1);
    applyMemStimulus(1'b0, 1'b0, 6'd10, 16'h1234);
    applyMemStimulus(1'b0, 1'b1, 6'd10, 16'h0000);
    rstn = 1'b0;
    #1;
    checkOutput("arst_fifo_out", fifo_out, 16'h0000);
    checkOutput("arst_empty", {15'd0, fifo_empty}, 16'h0001);
    checkOutput("arst_full", {15'd0, fifo_full}, 16'h0000);
    checkOutput("arst_Q", Q, 16'h0000);
    modelQ.delete();
    expOut.delete();
    lastOut = '0;
    qModel  = '0;
    for (int i = 0; i < 64; i++) memModel[i] = '0;

    // Requests while reset is held must be ignored
    valid_in = 1'b1;
    din      = 16'h7777;
    rd_en    = 1'b1;
    CEN      = 1'b0;
    WEN      = 1'b0;
    A        = 6'd20;
    D        = 16'h4321;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    rd_en    = 1'b0;
    CEN      = 1'b1;
    WEN      = 1'b1;
    checkOutput("inrst_empty", {15'd0, fifo_empty}, 16'h0001);
    checkOutput("inrst_out", fifo_out, 16'h0000);
    #2;
    rstn = 1'b1;

    applyMemStimulus(1'b0, 1'b1, 6'd10, 16'h0000);
    applyMemStimulus(1'b0, 1'b1, 6'd20, 16'h0000);
    applyStimulus(1'b0, 16'h0000, 1'b1);
    applyStimulus(1'b0, 16'h0000, 1'b1);
    applyStimulus(1'b1, 16'h2468, 1'b0);
    applyStimulus(1'b0, 16'h0000, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
